// File: rtl/uart_rx_if.sv
// Byte-level receive interface of the UART receiver: serial line in, received byte and status out.
// The slave modport is the receiver itself; the master modport is the line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its centre and reports the byte or a
// framing error as a single-cycle pulse.
module uart_rx #(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 115200
) (
  input logic      clk,
  input logic      resetn,
  uart_rx_if.slave bus
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic             sync1_r;
  logic             sync2_r;
  logic             rx_prev_r;
  logic             rx_s;
  logic             fall_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_nxt_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_nxt_s;
  logic [7:0]       rx_data_r;
  logic [7:0]       rx_data_nxt_s;
  logic             rx_valid_r;
  logic             rx_valid_nxt_s;
  logic             frame_err_r;
  logic             frame_err_nxt_s;
  logic             busy_r;

  assign rx_s   = sync2_r;
  // Only a genuine high-to-low transition starts a frame, so a line stuck low stays idle.
  assign fall_s = rx_prev_r & ~rx_s;

  // Two-flop synchronizer plus the previous synchronized value for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= bus.rx;
      sync2_r   <= sync1_r;
      rx_prev_r <= sync2_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fall_s) state_nxt_s = START;
        else        state_nxt_s = IDLE;
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          if (rx_s) state_nxt_s = IDLE;
          else      state_nxt_s = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if ((cnt_r == BAUD_LAST) && (bit_idx_r == 3'd7)) state_nxt_s = STOP;
        else                                             state_nxt_s = DATA;
      end
      STOP: begin
        if (cnt_r == BAUD_LAST) state_nxt_s = IDLE;
        else                    state_nxt_s = STOP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: counter, bit index, shift register and next values of the output pulses.
  always_comb begin
    cnt_nxt_s       = cnt_r + CNT_ONE;
    bit_idx_nxt_s   = bit_idx_r;
    shift_nxt_s     = shift_r;
    rx_data_nxt_s   = rx_data_r;
    rx_valid_nxt_s  = 1'b0;
    frame_err_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s     = CNT_ZERO;
        bit_idx_nxt_s = 3'd0;
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt_s     = CNT_ZERO;
          bit_idx_nxt_s = 3'd0;
        end else begin
          cnt_nxt_s     = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == BAUD_LAST) begin
          shift_nxt_s[bit_idx_r] = rx_s;
          cnt_nxt_s              = CNT_ZERO;
          bit_idx_nxt_s          = bit_idx_r + 3'd1;
        end else begin
          cnt_nxt_s              = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == BAUD_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (rx_s) begin
            rx_data_nxt_s  = shift_r;
            rx_valid_nxt_s = 1'b1;
          end else begin
            frame_err_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_nxt_s     = CNT_ZERO;
        bit_idx_nxt_s = 3'd0;
      end
    endcase
  end

  // Datapath and registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      bit_idx_r   <= bit_idx_nxt_s;
      shift_r     <= shift_nxt_s;
      rx_data_r   <= rx_data_nxt_s;
      rx_valid_r  <= rx_valid_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: random and directed frames are compared
// against a frame-level model (good stop bit -> byte delivered, bad stop bit -> framing error).
module tb_uart_rx;

  localparam int BIT_CYC = 16;
  // Start-bit edge to visible rx_valid: 2 synchronizer flops, 1 cycle to enter START,
  // half a bit plus 9 bits to the stop sample, observed on the following half-cycle.
  localparam longint VALID_LAT = 64'd2 + 64'd1 + 64'd8 + 64'd9 * 64'd16;

  logic clk;
  logic resetn;
  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_data;
  int         exp_ferr;
  int         ferr_cnt;
  int         both_cnt;
  logic       busy_seen;
  longint     cyc = 0;
  longint     last_valid_cyc;

  always @(posedge clk) cyc <= cyc + 64'd1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      obs_q.push_back(bus.rx_data);
      last_valid_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if ((bus.rx_valid === 1'b1) && (bus.frame_err === 1'b1)) both_cnt = both_cnt + 1;
    if (bus.busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic clear_sb();
    obs_q.delete();
    exp_q.delete();
    exp_ferr  = 0;
    ferr_cnt  = 0;
    both_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  // Sends one frame and records what an ideal receiver must report for it.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    if (stop) begin
      exp_q.push_back(b);
      exp_data = b;
    end else begin
      exp_ferr = exp_ferr + 1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.rx = 1'($urandom_range(0, 1));
      n_tests++;
      if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b busy=%b expected all zero",
                 bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy);
      end
    end
    bus.rx = 1'b1;
    @(negedge clk);
    resetn   = 1'b1;
    exp_data = 8'h00;
    idle(20);
  endtask

  task automatic test_single();
    longint c0;
    clear_sb();
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++; $display("FAIL single_data: got %h expected %h", obs_q[0], exp_q[0]);
      end
      n_tests++;
      if (last_valid_cyc - c0 != VALID_LAT) begin
        n_fail++; $display("FAIL single_latency: got %0d expected %0d", last_valid_cyc - c0, VALID_LAT);
      end
    end
    n_tests++;
    if (bus.rx_data !== exp_data) begin
      n_fail++; $display("FAIL single_hold: got %h expected %h", bus.rx_data, exp_data);
    end
    n_tests++;
    if (ferr_cnt != exp_ferr) begin
      n_fail++; $display("FAIL single_ferr: got %0d expected %0d", ferr_cnt, exp_ferr);
    end
    n_tests++;
    if ((busy_seen !== 1'b1) || (bus.busy !== 1'b0)) begin
      n_fail++; $display("FAIL single_busy: seen=%b now=%b expected seen=1 now=0", busy_seen, bus.busy);
    end
  endtask

  task automatic test_glitch();
    clear_sb();
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    n_tests++;
    if ((busy_seen !== 1'b1) || (bus.busy !== 1'b0)) begin
      n_fail++; $display("FAIL glitch_busy: seen=%b now=%b expected seen=1 now=0", busy_seen, bus.busy);
    end
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL glitch_valid: got %0d pulses expected 0", obs_q.size());
    end
    n_tests++;
    if (ferr_cnt != 0) begin
      n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt);
    end
    n_tests++;
    if (bus.rx_data !== exp_data) begin
      n_fail++; $display("FAIL glitch_hold: got %h expected %h", bus.rx_data, exp_data);
    end
  endtask

  task automatic test_frame_err();
    clear_sb();
    send_frame(8'h3C, 1'b0);
    busy_seen = 1'b0;
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    n_tests++;
    if (ferr_cnt != exp_ferr) begin
      n_fail++; $display("FAIL ferr_count: got %0d expected %0d", ferr_cnt, exp_ferr);
    end
    n_tests++;
    if (busy_seen !== 1'b0) begin
      n_fail++; $display("FAIL ferr_break_busy: got %b expected 0", busy_seen);
    end
    n_tests++;
    if (bus.rx_data !== exp_data) begin
      n_fail++; $display("FAIL ferr_hold: got %h expected %h", bus.rx_data, exp_data);
    end
    idle(16);
    send_frame(8'h81, 1'b1);
    idle(20);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ferr_recover_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++; $display("FAIL ferr_recover_data: got %h expected %h", obs_q[0], exp_q[0]);
      end
    end
    n_tests++;
    if ((ferr_cnt != exp_ferr) || (both_cnt != 0)) begin
      n_fail++; $display("FAIL ferr_total: got ferr=%0d both=%0d expected ferr=%0d both=0",
                         ferr_cnt, both_cnt, exp_ferr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] perm[256];
    logic [7:0] tmp;
    int         j;
    clear_sb();
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    for (int i = 0; i < 256; i++) send_frame(perm[i], 1'b1);
    idle(20);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if ((ferr_cnt != 0) || (both_cnt != 0)) begin
      n_fail++; $display("FAIL b2b_ferr: got ferr=%0d both=%0d expected 0", ferr_cnt, both_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    clear_sb();
    bits = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(bits[i]);
    bus.rx = bits[5];
    repeat (BIT_CYC / 2) @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got data=%h valid=%b ferr=%b busy=%b expected all zero",
               bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy);
    end
    resetn   = 1'b1;
    exp_data = 8'h00;
    idle(40);
    n_tests++;
    if ((obs_q.size() != 0) || (ferr_cnt != 0)) begin
      n_fail++; $display("FAIL midreset_abort: got valid=%0d ferr=%0d expected 0", obs_q.size(), ferr_cnt);
    end
    send_frame(8'hC3, 1'b1);
    idle(20);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midreset_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++; $display("FAIL midreset_data: got %h expected %h", obs_q[0], exp_q[0]);
      end
    end
    n_tests++;
    if (bus.rx_data !== exp_data) begin
      n_fail++; $display("FAIL midreset_hold: got %h expected %h", bus.rx_data, exp_data);
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.rx = 1'b1;
    clear_sb();
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 125_000_000, receiver clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 Derived constant BAUD_CNT = CLK_FREQ/BAUD_RATE, integer division, giving clocks per bit (1085 at the defaults); HALF_CNT = BAUD_CNT/2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1 frames (1 start bit, 8 data bits LSB first, no parity, 1 stop bit).
REQ-007 rx_data  output  8  last correctly received byte, registered.
REQ-008 rx_valid  output  1  one-cycle pulse: rx_data updated with a new byte.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 busy  output  1  high while a frame is being received (START, DATA or STOP state).

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic SHALL use only the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA and STOP; one baud counter (width ceil(log2(BAUD_CNT))) and a 3-bit bit index SHALL be used.
REQ-013 IDLE: on a falling edge of rx_s (previous rx_s = 1, current rx_s = 0) SHALL go to START with counter = 0; a line held low SHALL NOT start a frame.
REQ-014 START: the counter SHALL increment each cycle; at count = HALF_CNT-1 SHALL sample rx_s; if 0, go to DATA with counter = 0 and bit index = 0; if 1 (glitch), return to IDLE with no output pulse.
REQ-015 DATA: at count = BAUD_CNT-1 SHALL shift rx_s into bit position [bit index] (LSB first), clear the counter, increment the bit index; after the bit with index 7, SHALL go to STOP.
REQ-016 STOP: at count = BAUD_CNT-1 SHALL sample rx_s; if 1, load rx_data from the shift register and pulse rx_valid on the next cycle; if 0, pulse frame_err on the next cycle and leave rx_data unchanged; SHALL go to IDLE in both cases.
REQ-017 Samples SHALL occur at bit centres: data bit k at HALF_CNT + (k+1)*BAUD_CNT cycles after START entry; stop bit at HALF_CNT + 9*BAUD_CNT cycles after START entry.
REQ-018 rx_valid and frame_err SHALL never assert in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-019 busy SHALL be 0 in IDLE and 1 in every other state.
REQ-020 Back-to-back frames with no idle gap SHALL be received: the falling edge from stop (1) to the next start (0) is detected in IDLE.
REQ-021 After a framing error with rx still low (break condition), no new frame SHALL start until rx_s goes high and then falls again.
REQ-022 rx_data SHALL hold its value until the next valid frame; no output-side backpressure exists; a consumer that misses the pulse loses the byte.

Reset
REQ-023 When resetn = 0, asynchronously: state = IDLE, counter = 0, bit index = 0, shift register = 0, synchronizer flops = 1, rx_data = 0x00, rx_valid = 0, frame_err = 0, busy = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse; after release, reception SHALL resume only at the next falling edge.

Verification (parameters CLK_FREQ=16, BAUD_RATE=1 so BAUD_CNT=16, HALF_CNT=8)
REQ-025 Reset: resetn=0 with rx toggling -> rx_data=0x00, rx_valid=0, frame_err=0, busy=0 throughout.
REQ-026 Single frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles) -> exactly one rx_valid pulse, rx_data=0xA5, frame_err=0, busy back to 0 after the stop sample.
REQ-027 Glitch: rx low for 4 cycles, then high -> busy high briefly, then IDLE; no rx_valid, no frame_err, rx_data unchanged.
REQ-028 Framing error: frame 0x3C with stop bit 0, rx held low for 40 cycles, then frame 0x81 -> one frame_err pulse, rx_data stays at its previous value, no false frame during the low hold, then rx_valid with rx_data=0x81.
REQ-029 Back-to-back: frames 0x00 then 0xFF with no gap, then a 256-value random sweep -> one rx_valid per frame, each rx_data equals the byte sent, zero frame_err.
REQ-030 Reset mid-frame: resetn pulsed low during data bit 4 of 0x5A, then frame 0xC3 -> no pulse for 0x5A; rx_valid with rx_data=0xC3.
